// File: rtl/vector_seq.sv
// Reset/NMI/IRQ/BRK vector sequencer: pushes PC and P, fetches the vector and
// drives the PC load strobes while holding the decoder off through busy.
module vector_seq #(
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RST_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        brk_req,
    input  logic        insn_boundary,
    input  logic [7:0]  pc_h,
    input  logic [7:0]  pc_l,
    input  logic [7:0]  p_reg,
    input  logic [7:0]  sp,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    output logic        sp_dec,
    output logic [7:0]  pc_l_data,
    output logic        load_pc_l,
    output logic        load_pc_h_mem,
    output logic        set_i,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        StRst1, StRst2, StRst3, StIdle, StPushH, StPushL, StPushP, StVecL, StVecH, StLoadH
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [15:0] r_vec;
    logic [15:0] w_vec_d;
    logic        r_b;
    logic        w_b_d;
    logic        r_nmi_prev;
    logic        r_nmi_pend;
    logic        w_nmi_pend_d;

    logic        w_nmi_edge;
    logic        w_sel_nmi;
    logic        w_sel_brk;
    logic        w_sel_irq;

    assign w_nmi_edge = r_nmi_prev & ~nmi_n;
    assign w_sel_nmi  = r_nmi_pend & (insn_boundary | brk_req);
    assign w_sel_brk  = brk_req;
    assign w_sel_irq  = insn_boundary & ~irq_n & ~i_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StRst1;
            r_vec      <= RST_VEC;
            r_b        <= 1'b0;
            r_nmi_prev <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_vec      <= w_vec_d;
            r_b        <= w_b_d;
            r_nmi_prev <= nmi_n;
            r_nmi_pend <= w_nmi_pend_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_vec_d      = r_vec;
        w_b_d        = r_b;
        w_nmi_pend_d = r_nmi_pend;
        unique case (r_state)
            StRst1:  w_state_d = StRst2;
            StRst2:  w_state_d = StRst3;
            StRst3:  w_state_d = StVecL;
            StIdle: begin
                // A BRK fetched alongside a pending NMI keeps its B bit but takes the NMI vector.
                if (w_sel_nmi) begin
                    w_vec_d      = NMI_VEC;
                    w_b_d        = brk_req;
                    w_nmi_pend_d = 1'b0;
                    w_state_d    = StPushH;
                end else if (w_sel_brk) begin
                    w_vec_d   = IRQ_VEC;
                    w_b_d     = 1'b1;
                    w_state_d = StPushH;
                end else if (w_sel_irq) begin
                    w_vec_d   = IRQ_VEC;
                    w_b_d     = 1'b0;
                    w_state_d = StPushH;
                end
            end
            StPushH: w_state_d = StPushL;
            StPushL: w_state_d = StPushP;
            StPushP: w_state_d = StVecL;
            StVecL:  w_state_d = StVecH;
            StVecH:  w_state_d = StLoadH;
            StLoadH: w_state_d = StIdle;
            default: w_state_d = StRst1;
        endcase
        // A new edge on the selection cycle must not be lost.
        if (w_nmi_edge) begin
            w_nmi_pend_d = 1'b1;
        end
    end

    always_comb begin
        mem_addr      = 16'h0000;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_wdata     = 8'h00;
        sp_dec        = 1'b0;
        pc_l_data     = 8'h00;
        load_pc_l     = 1'b0;
        load_pc_h_mem = 1'b0;
        set_i         = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        unique case (r_state)
            StRst1, StRst2, StRst3: begin
                mem_rd   = 1'b1;
                mem_addr = {STACK_PAGE, sp};
                sp_dec   = 1'b1;
            end
            StIdle:  busy = 1'b0;
            StPushH, StPushL, StPushP: begin
                mem_wr   = 1'b1;
                mem_addr = {STACK_PAGE, sp};
                sp_dec   = 1'b1;
                if (r_state == StPushH) begin
                    mem_wdata = pc_h;
                end else if (r_state == StPushL) begin
                    mem_wdata = pc_l;
                end else begin
                    mem_wdata = {p_reg[7:6], 1'b1, r_b, p_reg[3:0]};
                end
            end
            StVecL: begin
                mem_rd   = 1'b1;
                mem_addr = r_vec;
            end
            StVecH: begin
                mem_rd    = 1'b1;
                mem_addr  = r_vec + 16'd1;
                pc_l_data = mem_rdata;
                load_pc_l = 1'b1;
            end
            StLoadH: begin
                load_pc_h_mem = 1'b1;
                set_i         = 1'b1;
                done          = 1'b1;
            end
            default: busy = 1'b1;
        endcase
        // Bus and PC strobes must fall as soon as reset asserts, not at the next edge.
        if (!rst_n) begin
            mem_addr      = 16'h0000;
            mem_rd        = 1'b0;
            mem_wr        = 1'b0;
            mem_wdata     = 8'h00;
            sp_dec        = 1'b0;
            pc_l_data     = 8'h00;
            load_pc_l     = 1'b0;
            load_pc_h_mem = 1'b0;
            set_i         = 1'b0;
            done          = 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_seq.sv
// Randomised bench for vector_seq with a transaction-level model of the
// expected stack pushes, vector reads and PC/SP results.
module tb_vector_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic        brk_req;
    logic        insn_boundary;
    logic [15:0] pc;
    logic [7:0]  pc_h;
    logic [7:0]  pc_l;
    logic [7:0]  p_reg;
    logic [7:0]  sp;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        sp_dec;
    logic [7:0]  pc_l_data;
    logic        load_pc_l;
    logic        load_pc_h_mem;
    logic        set_i;
    logic        busy;
    logic        done;

    assign pc_h = pc[15:8];
    assign pc_l = pc[7:0];

    always #5 clk = ~clk;

    vector_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .nmi_n         (nmi_n),
        .irq_n         (irq_n),
        .i_flag        (i_flag),
        .brk_req       (brk_req),
        .insn_boundary (insn_boundary),
        .pc_h          (pc_h),
        .pc_l          (pc_l),
        .p_reg         (p_reg),
        .sp            (sp),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_wdata     (mem_wdata),
        .sp_dec        (sp_dec),
        .pc_l_data     (pc_l_data),
        .load_pc_l     (load_pc_l),
        .load_pc_h_mem (load_pc_h_mem),
        .set_i         (set_i),
        .busy          (busy),
        .done          (done)
    );

    logic [7:0]  mem [0:65535];
    logic [23:0] wr_q [$];
    logic [15:0] rd_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tick_no;
    int          done_at;
    int          busy_cnt;
    int          seti_cnt;
    int          excl_err;
    logic        m_prev;
    logic        m_pend;
    logic        m_clr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        rd_q.delete();
        tick_no  = 0;
        done_at  = 0;
        busy_cnt = 0;
        seti_cnt = 0;
        excl_err = 0;
    endtask

    // One clock: sample outputs on the falling edge, then play the PC, SP,
    // memory and NMI-pending roles just after the rising edge.
    task automatic tick();
        logic        s_rd, s_wr, s_dec, s_lpl, s_lph;
        logic [15:0] s_addr;
        logic [7:0]  s_wdata, s_pcl, s_rdata;
        @(negedge clk);
        s_rd = mem_rd; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_wdata;
        s_dec = sp_dec; s_lpl = load_pc_l; s_lph = load_pc_h_mem;
        s_pcl = pc_l_data; s_rdata = mem_rdata;
        tick_no++;
        if (s_rd && s_wr) excl_err++;
        if (s_wr) wr_q.push_back({s_addr, s_wdata});
        if (s_rd) rd_q.push_back(s_addr);
        if (busy) busy_cnt++;
        if (set_i) seti_cnt++;
        if (done && done_at == 0) done_at = tick_no;
        @(posedge clk);
        #1;
        if (s_dec) sp = sp - 8'd1;
        if (s_wr) mem[s_addr] = s_wdata;
        if (s_lpl) pc[7:0] = s_pcl;
        if (s_lph) pc[15:8] = s_rdata;
        if (s_rd) mem_rdata = mem[s_addr];
        if (!rst_n) begin
            m_pend = 1'b0;
            m_prev = 1'b0;
        end else begin
            if (m_clr) m_pend = 1'b0;
            if (m_prev && !nmi_n) m_pend = 1'b1;
            m_prev = nmi_n;
        end
        m_clr = 1'b0;
    endtask

    task automatic run_reset();
        logic [7:0]  sp0;
        logic [15:0] exp_pc;
        sp0    = sp;
        exp_pc = {mem[16'hFFFD], mem[16'hFFFC]};
        clear_log();
        rst_n = 1'b1;
        for (int i = 0; i < 10 && done_at == 0; i++) tick();
        check_eq("rst_nwr", wr_q.size(), 0);
        check_eq("rst_nrd", rd_q.size(), 5);
        for (int i = 0; i < 3; i++)
            if (i < rd_q.size()) check_eq("rst_dummy", rd_q[i], {8'h01, sp0 - 8'(i)});
        if (rd_q.size() > 4) begin
            check_eq("rst_vecl", rd_q[3], 16'hFFFC);
            check_eq("rst_vech", rd_q[4], 16'hFFFD);
        end
        check_eq("rst_done", done_at, 6);
        check_eq("rst_busy", busy_cnt, 6);
        check_eq("rst_pc", pc, exp_pc);
        check_eq("rst_sp", sp, sp0 - 8'd3);
        check_eq("rst_excl", excl_err, 0);
        tick();
        check_eq("rst_idle", busy, 1'b0);
    endtask

    // Select one event (or none) from the given IDLE inputs and check the whole sequence.
    task automatic run_event(input logic bnd, input logic brk, input logic irqn,
                             input logic iflag);
        int          kind;
        logic [15:0] vec;
        logic        b;
        logic [7:0]  sp0, p0;
        logic [15:0] pc0, exp_pc;
        logic [7:0]  exp_p;
        if (m_pend && (bnd || brk)) begin
            kind = 1; vec = 16'hFFFA; b = brk;
        end else if (brk) begin
            kind = 2; vec = 16'hFFFE; b = 1'b1;
        end else if (bnd && !irqn && !iflag) begin
            kind = 3; vec = 16'hFFFE; b = 1'b0;
        end else begin
            kind = 0; vec = 16'hFFFE; b = 1'b0;
        end
        sp0 = sp; p0 = p_reg; pc0 = pc;
        exp_pc = {mem[vec + 16'd1], mem[vec]};
        exp_p  = (p0 & 8'hEF) | 8'h20 | (b ? 8'h10 : 8'h00);
        insn_boundary = bnd; brk_req = brk; irq_n = irqn; i_flag = iflag;
        if (kind == 1) m_clr = 1'b1;
        clear_log();
        tick();
        insn_boundary = 1'b0;
        brk_req = 1'b0;
        if (kind == 0) begin
            for (int i = 0; i < 3; i++) tick();
            check_eq("none_wr", wr_q.size(), 0);
            check_eq("none_rd", rd_q.size(), 0);
            check_eq("none_busy", busy_cnt, 0);
        end else begin
            for (int i = 0; i < 10 && done_at == 0; i++) tick();
            check_eq("ev_nwr", wr_q.size(), 3);
            if (wr_q.size() > 2) begin
                check_eq("ev_pch", wr_q[0], {8'h01, sp0, pc0[15:8]});
                check_eq("ev_pcl", wr_q[1], {8'h01, sp0 - 8'd1, pc0[7:0]});
                check_eq("ev_p", wr_q[2], {8'h01, sp0 - 8'd2, exp_p});
            end
            check_eq("ev_nrd", rd_q.size(), 2);
            if (rd_q.size() > 1) begin
                check_eq("ev_vecl", rd_q[0], vec);
                check_eq("ev_vech", rd_q[1], vec + 16'd1);
            end
            check_eq("ev_done", done_at, 7);
            check_eq("ev_busy", busy_cnt, 6);
            check_eq("ev_seti", seti_cnt, 1);
            check_eq("ev_pc", pc, exp_pc);
            check_eq("ev_sp", sp, sp0 - 8'd3);
            check_eq("ev_excl", excl_err, 0);
        end
        irq_n = 1'b1;
    endtask

    task automatic rand_vectors();
        for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
        brk_req = 1'b0; insn_boundary = 1'b0;
        pc = 16'h0000; p_reg = 8'h00; sp = 8'hFD; mem_rdata = 8'h00;
        m_prev = 1'b0; m_pend = 1'b0; m_clr = 1'b0;
        rand_vectors();
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        #2;
        check_eq("rst_busy_hi", busy, 1'b1);
        check_eq("rst_rd0", mem_rd, 1'b0);
        check_eq("rst_addr0", mem_addr, 16'h0000);
        check_eq("rst_done0", done, 1'b0);
        check_eq("rst_pcl0", pc_l_data, 8'h00);
        tick(); tick();
        run_reset();
        check_eq("rst_pc1234", pc, 16'h1234);

        // IRQ directed, then masked
        pc = 16'hC123; p_reg = 8'h00; sp = 8'hFF;
        run_event(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("irq_mem_p", mem[16'h01FD], 8'h20);
        run_event(1'b1, 1'b0, 1'b0, 1'b1);

        // BRK
        p_reg = 8'h81; sp = 8'hF0;
        run_event(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("brk_mem_p", mem[16'h01EE], 8'hB1);

        // NMI edge held low with two boundaries
        tick();
        nmi_n = 1'b0;
        tick();
        run_event(1'b1, 1'b0, 1'b1, 1'b1);
        run_event(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        nmi_n = 1'b1;
        tick();

        // Hijack: BRK with NMI pending
        nmi_n = 1'b0;
        tick();
        run_event(1'b0, 1'b1, 1'b1, 1'b1);
        nmi_n = 1'b1;
        tick();
        // NMI wins over IRQ at a boundary
        nmi_n = 1'b0;
        tick();
        run_event(1'b1, 1'b0, 1'b0, 1'b0);
        nmi_n = 1'b1;
        tick();

        // Randomised events
        for (int it = 0; it < 30; it++) begin
            sp = 8'($urandom); pc = 16'($urandom); p_reg = 8'($urandom);
            rand_vectors();
            nmi_n = 1'($urandom_range(0, 1));
            tick();
            run_event(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        nmi_n = 1'b1;
        tick(); tick();

        // Reset during PUSH_L with an NMI edge pending
        sp = 8'h80;
        insn_boundary = 1'b1; irq_n = 1'b0; i_flag = 1'b0;
        tick();
        insn_boundary = 1'b0;
        nmi_n = 1'b0;
        tick();
        check_eq("mid_wr_hi", mem_wr, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_wr0", mem_wr, 1'b0);
        check_eq("mid_rd0", mem_rd, 1'b0);
        check_eq("mid_dec0", sp_dec, 1'b0);
        check_eq("mid_addr0", mem_addr, 16'h0000);
        check_eq("mid_busy", busy, 1'b1);
        irq_n = 1'b1;
        tick(); tick();
        sp = 8'($urandom);
        rand_vectors();
        run_reset();
        run_event(1'b1, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
